// File: rtl/div_unit.sv
// Multi-cycle integer divider for the EX stage: DIV/DIVU/REM/REMU using a
// restoring radix-2 datapath, one quotient bit per cycle, stall-based handshake.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Per-operation attributes captured at launch
  typedef struct packed {
    logic is_rem;
    logic neg_q;
    logic neg_r;
  } op_attr_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  logic [XLEN-1:0] prem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  op_attr_t        attr;

  // Launch-side decode
  logic            op_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, ovf, special, launch;
  logic [XLEN-1:0] special_res;

  always_comb begin
    op_signed   = ~div_op[0];
    a_neg       = op_signed & rs1_data[XLEN-1];
    b_neg       = op_signed & rs2_data[XLEN-1];
    // Negating INT_MIN wraps to itself, which is the correct unsigned magnitude.
    a_mag       = a_neg ? -rs1_data : rs1_data;
    b_mag       = b_neg ? -rs2_data : rs2_data;
    div_zero    = (rs2_data == '0);
    ovf         = op_signed & (rs1_data == INT_MIN) & (rs2_data == '1);
    special     = div_zero | ovf;
    launch      = (state == IDLE) & start & ~flush;
    if (div_zero)
      special_res = div_op[1] ? rs1_data : '1;
    else
      special_res = div_op[1] ? '0 : INT_MIN;
  end

  // One restoring step: shift the next dividend bit into a 33-bit working
  // remainder, subtract the divisor if it fits.
  logic [XLEN:0]   prem_sh;
  logic [XLEN-1:0] diff, prem_nxt, quo_nxt;
  logic            take;
  logic [XLEN-1:0] q_fin, r_fin, fin;

  always_comb begin
    prem_sh  = {prem, quo[XLEN-1]};
    take     = (prem_sh >= {1'b0, dvs});
    diff     = prem_sh[XLEN-1:0] - dvs;
    prem_nxt = take ? diff : prem_sh[XLEN-1:0];
    quo_nxt  = {quo[XLEN-2:0], take};
    q_fin    = attr.neg_q ? -quo_nxt : quo_nxt;
    r_fin    = attr.neg_r ? -prem_nxt : prem_nxt;
    fin      = attr.is_rem ? r_fin : q_fin;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = special ? DONE : BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Stall is derived from state/start/flush only, never from result_valid.
  assign stall        = rst_n & ~flush & (((state == IDLE) & start) | (state == BUSY));
  assign result_valid = (state == DONE) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      prem   <= '0;
      quo    <= '0;
      dvs    <= '0;
      attr   <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        attr.is_rem <= div_op[1];
        attr.neg_q  <= a_neg ^ b_neg;
        attr.neg_r  <= a_neg;
        prem        <= '0;
        quo         <= a_mag;
        dvs         <= b_mag;
        cnt         <= '1;
        if (special) result <= special_res;
      end else if (state == BUSY && !flush) begin
        prem <= prem_nxt;
        quo  <= quo_nxt;
        cnt  <= cnt - 5'd1;
        if (cnt == '0) result <= fin;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a cycle-scheduled driver pushes expected
// results from an arithmetic reference model; a negedge monitor checks them.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .div_op(div_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .stall(stall), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    int          t;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        exp_stall = 1'b0;
  logic [31:0] last_res = '0;
  bit          done_flag = 1'b0;
  bit          final_done = 1'b0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) begin
      if (op[1]) return $signed(a) % $signed(b);
      return $signed(a) / $signed(b);
    end
    if (op[1]) return a % b;
    return a / b;
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      last_res = '0;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_valid", {31'b0, result_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
    end else begin
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'b0, result_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 32'(cyc - e.t), 32'(e.lat));
          last_res = e.res;
        end
      end else begin
        chk("result_hold", result, last_res);
      end
    end
    if (done_flag && !final_done) begin
      chk("sb_empty", 32'(sb.size()), 32'd0);
      final_done = 1'b1;
    end
  end

  task automatic drive(bit s, logic [1:0] op, logic [31:0] a, logic [31:0] b, bit f, bit es);
    @(posedge clk);
    #1;
    start = s; div_op = op; rs1_data = a; rs2_data = b; flush = f; exp_stall = es;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Launch at T, hold start through BUSY and DONE (pipeline frozen until DONE).
  task automatic run_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   lat;
    lat = is_special(op, a, b) ? 1 : 33;
    drive(1'b1, op, a, b, 1'b0, 1'b1);
    e.res = ref_res(op, a, b); e.t = cyc; e.lat = lat;
    sb.push_back(e);
    for (int k = 1; k < lat; k++) drive(1'b1, op, a, b, 1'b0, 1'b1);
    drive(1'b1, op, a, b, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 3))
      0: return 32'h8000_0000;
      1: return $urandom_range(0, 200);
      2: return $urandom;
      default: return -$urandom_range(1, 200);
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return $urandom_range(1, 20);
      3: return $urandom;
      default: return -$urandom_range(1, 20);
    endcase
  endfunction

  initial begin
    exp_stall = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    run_op(OP_DIV,  32'd100,       32'd7);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2);
    run_op(OP_REMU, 32'hFFFF_FFF9, 32'd2);
    idle(1);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0);
    run_op(OP_REM,  32'h0000_1234, 32'd0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV,  32'h8000_0000, 32'd1);
    idle(2);

    // Flush during BUSY step 10: no result, then a clean full-latency relaunch.
    for (int k = 0; k < 10; k++) drive(1'b1, OP_DIV, 32'd5000, 32'd3, 1'b0, 1'b1);
    drive(1'b1, OP_DIV, 32'd5000, 32'd3, 1'b1, 1'b0);
    idle(3);
    run_op(OP_DIV, 32'd5000, 32'd3);
    idle(1);

    // Flush beats start in IDLE.
    drive(1'b1, OP_DIVU, 32'd9, 32'd0, 1'b1, 1'b0);
    idle(3);

    // Asynchronous reset mid-BUSY, sampled before any clock edge.
    for (int k = 0; k < 6; k++) drive(1'b1, OP_REMU, 32'd77777, 32'd10, 1'b0, 1'b1);
    @(posedge clk); #4 rst_n = 1'b0;
    exp_stall = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    start = 1'b0;
    idle(2);
    run_op(OP_REMU, 32'd77777, 32'd10);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick_a();
      b  = pick_b();
      run_op(op, a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    done_flag = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(negedge clk);
    if (!final_done) begin
      n_chk++; n_fail++;
      $display("FAIL final_check: monitor did not complete");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  EX stage holds a valid DIV/DIVU/REM/REMU; held high while stalled.
REQ-005 SHALL have port div_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port rs1_data  input  32  dividend.
REQ-007 SHALL have port rs2_data  input  32  divisor.
REQ-008 SHALL have port flush  input  1  EX-stage flush (jump/branch taken); aborts any operation.
REQ-009 SHALL have port stall  output  1  pipeline stall request, feeds the hazard unit stall input.
REQ-010 SHALL have port result  output  32  quotient or remainder.
REQ-011 SHALL have port result_valid  output  1  result is valid this cycle.

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch div_op, operand magnitudes and sign flags, and assert stall combinationally in that same cycle T.
REQ-014 SHALL, for a non-special launch, move IDLE->BUSY and perform one restoring radix-2 step per cycle for exactly 32 cycles (T+1..T+32), with stall=1 throughout.
REQ-015 SHALL move BUSY->DONE after the 32nd step, a 5-bit counter reaching 0.
REQ-016 SHALL, in DONE (cycle T+33), drive stall=0 and result_valid=1 with result stable, ignore start, and move to IDLE on the next cycle.
REQ-017 SHALL treat divisor==0 as a special case: quotient 0xFFFFFFFF, remainder = dividend; IDLE->DONE directly, so result_valid is asserted at T+1.
REQ-018 SHALL treat signed overflow as a special case: DIV/REM with 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0; IDLE->DONE directly.
REQ-019 SHALL, for signed operations, divide magnitudes, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-020 SHALL compute the magnitude of 0x80000000 as unsigned 0x80000000 without overflow, using a 33-bit partial remainder.
REQ-021 SHALL, on flush=1 in any state, return to IDLE on the next edge and force stall=0 combinationally; result_valid is never asserted for the aborted operation.
REQ-022 SHALL give flush priority over start in IDLE: no launch occurs.
REQ-023 SHALL drive result_valid=0 in IDLE and BUSY; result holds its last value outside DONE.
REQ-024 SHALL keep stall independent of result_valid so the path to the hazard unit has no combinational loop.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force state IDLE, counter 0, result 0, result_valid 0, stall 0, and clear all operand/sign registers.
REQ-026 SHALL abort an operation cleanly on reset mid-BUSY; the first start after rst_n rises launches normally.

Verification
REQ-027 SHALL cover DIV with rs1=100, rs2=7, start at T -> stall=1 for T..T+32, result=14 and result_valid=1 at T+33.
REQ-028 SHALL cover REM with rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFF (-1) at T+33; REMU with the same operands -> result=1.
REQ-029 SHALL cover DIVU with rs1=0x1234, rs2=0 -> result=0xFFFFFFFF at T+1; REM of the same operands -> result=0x1234 at T+1.
REQ-030 SHALL cover DIV with 0x80000000 / 0xFFFFFFFF -> result=0x80000000 at T+1; REM of the same operands -> result=0.
REQ-031 SHALL cover flush asserted in BUSY step 10 -> stall=0 in the flush cycle, IDLE next cycle, no result_valid; a following start relaunches with the full 33-cycle latency.
REQ-032 SHALL cover rst_n low mid-BUSY -> outputs 0 immediately, without waiting for a clock edge; start held high through DONE -> exactly one result_valid pulse, then a new launch from IDLE.
